dmem_arbiter: RTL and testbench

Two-master arbiter sharing the 2 KB data memory between the CPU load/store port (m0) and a second bus master (m1, loader/debug port). It replaces direct CPU-to-memory wiring in the bridge path. It serialises accesses through a three-state FSM with round-robin fairness. It range-checks addresses, and out-of-range accesses complete with an error instead of touching memory.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 42 ++++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and memory map for the data-memory arbiter
//
// Purpose: state encoding, memory size default and memory-map constants
// used by dmem_arbiter and the bridge.
// Ports: none (package).

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Size of the on-chip data memory in bytes.
  localparam int MEM_BYTES_DEFAULT = 2048;

  // Memory map seen by the bridge.
  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] DMEM_LAST = 32'h0000_07FF;
  localparam logic [31:0] LED_ADDR  = 32'h0001_0000;

  // Master indices as carried in the latched owner bit.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter
//
// Purpose: grants one of two requesters; on a tie the requester that did
// not win last time is granted. The last winner is remembered internally
// and only updated when update_en is high and a grant is issued.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (last winner := m1)
//   req[1:0]   in   request vector, bit 0 = m0, bit 1 = m1
//   update_en  in   commit this cycle's grant as the new last winner
//   grant[1:0] out  one-hot grant (all zero when no request)

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant
);

  // 1 = m1 won last; resetting to 1 hands the first tie to m0.
  logic last_owner;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (update_en && (req != 2'b00)) begin
      last_owner <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter for the data memory
//
// Purpose: serialises accesses from m0 (CPU load/store) and m1 (loader /
// debug) onto one synchronous RAM port. Each access takes IDLE -> ISSUE ->
// RESP; out-of-range addresses complete with err and never strobe memory.
// Optional feature macro: DMEM_ARB_STATS_EN enables the performance
// counters; without it the counter ports are tied to zero.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m*_req/we/addr/wdata          master request, held until ack
//   m*_ack/rdata/err              one-cycle completion with read data/error
//   mem_addr/re/we/wdata          memory command, strobes last one cycle
//   mem_rdata                     RAM read data, one cycle after mem_re
//   cnt_m0/cnt_m1/cnt_conflict    completed accesses per master, tie cycles

import dmem_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       cnt_m0,
  output logic [31:0]       cnt_m1,
  output logic [31:0]       cnt_conflict
);

  // Unsigned full-width limit so huge addresses never alias into range.
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  arb_state_t        state_q, state_d;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              in_idle;
  logic              in_range;
  logic              resp_ok_read;
  logic [DATA_W-1:0] resp_data;

  assign req     = {m1_req, m0_req};
  assign in_idle = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .update_en (in_idle),
    .grant     (grant)
  );

  // State register and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && (req != 2'b00)) begin
        owner_q <= grant[1];
        we_q    <= grant[1] ? m1_we    : m0_we;
        addr_q  <= grant[1] ? m1_addr  : m0_addr;
        wdata_q <= grant[1] ? m1_wdata : m0_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything below decodes registered state only, so no req-to-output path.
  assign in_range     = (addr_q < MEM_LIMIT);
  assign resp_ok_read = (state_q == RESP) && in_range && !we_q;
  assign resp_data    = resp_ok_read ? mem_rdata : '0;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == ISSUE) && in_range && !we_q;
  assign mem_we    = (state_q == ISSUE) && in_range &&  we_q;

  assign m0_ack   = (state_q == RESP) && (owner_q == OWNER_M0);
  assign m1_ack   = (state_q == RESP) && (owner_q == OWNER_M1);
  assign m0_err   = m0_ack && !in_range;
  assign m1_err   = m1_ack && !in_range;
  assign m0_rdata = (owner_q == OWNER_M0) ? resp_data : '0;
  assign m1_rdata = (owner_q == OWNER_M1) ? resp_data : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cnt_m0_q, cnt_m1_q, cnt_conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_m0_q       <= '0;
      cnt_m1_q       <= '0;
      cnt_conflict_q <= '0;
    end else begin
      if (m0_ack) cnt_m0_q <= cnt_m0_q + 32'd1;
      if (m1_ack) cnt_m1_q <= cnt_m1_q + 32'd1;
      if (in_idle && m0_req && m1_req) cnt_conflict_q <= cnt_conflict_q + 32'd1;
    end
  end

  assign cnt_m0       = cnt_m0_q;
  assign cnt_m1       = cnt_m1_q;
  assign cnt_conflict = cnt_conflict_q;
`else
  assign cnt_m0       = 32'd0;
  assign cnt_m1       = 32'd0;
  assign cnt_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic [31:0] cnt_m0, cnt_m1, cnt_conflict;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cnt_m0(cnt_m0), .cnt_m1(cnt_m1), .cnt_conflict(cnt_conflict)
  );

  // Synchronous RAM attached to the memory port.
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[10:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[10:2]];
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        q0[$];
  acc_t        q1[$];
  logic [31:0] ref_mem [0:511];
  int          last_w;
  int          exp_cnt0, exp_cnt1, exp_conf;
  int          ack_m[$];
  int          ack_t[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic acc_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wdata;
    return a;
  endfunction

  function automatic acc_t rand_acc();
    logic [31:0] a;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 8)       a = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
    else if (sel == 8) a = 32'h800 + {28'd0, 4'($urandom_range(0, 15))};
    else               a = $urandom | 32'h8000_0000;
    return mk(1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  task automatic drive_heads();
    if (q0.size() > 0) begin
      m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
    end else begin
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    end
    if (q1.size() > 0) begin
      m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
    end else begin
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    q0.delete(); q1.delete();
    drive_heads();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_w = 1; exp_cnt0 = 0; exp_cnt1 = 0; exp_conf = 0;
  endtask

  // Cycle-level reference: a free arbiter picks on the sampling edge, the
  // strobe shows in the next window, the ack one window later, and the
  // arbiter is free again three edges after the pick.
  task automatic run_queues(input string tag, input int budget);
    int e, nf, ack_due, w, idx;
    acc_t cur;
    logic [1:0] r;
    logic [3:0] exp_ctl;
    logic [31:0] exp_rd;
    logic exp_err, inr;
    e = 0; nf = 0; ack_due = -1; w = 0; cur = '0; exp_rd = '0; exp_err = 1'b0;
    drive_heads();
    while (1) begin
      r = {m1_req, m0_req};
      @(posedge clk);
      e++;
      @(negedge clk);
      exp_ctl = 4'b0000;
      if (e >= nf) begin
        if (r == 2'b11) exp_conf++;
        if (r != 2'b00) begin
          if (r == 2'b01)      w = 0;
          else if (r == 2'b10) w = 1;
          else                 w = (last_w == 1) ? 0 : 1;
          last_w = w;
          cur = (w == 0) ? q0[0] : q1[0];
          inr = (cur.addr < 32'd2048);
          idx = int'(cur.addr[10:2]);
          exp_err = !inr;
          exp_rd = '0;
          if (inr && !cur.we) exp_rd = ref_mem[idx];
          if (inr && cur.we) ref_mem[idx] = cur.wdata;
          exp_ctl[1] = inr && !cur.we;
          exp_ctl[0] = inr && cur.we;
          ack_due = e + 1;
          nf = e + 3;
        end
      end else if (e == ack_due) begin
        exp_ctl[(w == 0) ? 3 : 2] = 1'b1;
      end
      n_total++;
      if ({m0_ack, m1_ack, mem_re, mem_we} !== exp_ctl)
        $display("FAIL %s ctl e=%0d {ack0,ack1,re,we} got %b want %b", tag, e, {m0_ack, m1_ack, mem_re, mem_we}, exp_ctl);
      else n_pass++;
      if (exp_ctl[1] || exp_ctl[0]) begin
        n_total++;
        if (mem_addr !== cur.addr || (exp_ctl[0] && mem_wdata !== cur.wdata))
          $display("FAIL %s mem_cmd addr/wdata got %h/%h want %h/%h", tag, mem_addr, mem_wdata, cur.addr, cur.wdata);
        else n_pass++;
      end
      if (exp_ctl[3] || exp_ctl[2]) begin
        n_total++;
        if (w == 0) begin
          if (m0_rdata !== exp_rd || m0_err !== exp_err || m1_rdata !== 32'd0 || m1_err !== 1'b0)
            $display("FAIL %s m0_resp rdata/err got %h/%b want %h/%b", tag, m0_rdata, m0_err, exp_rd, exp_err);
          else n_pass++;
          void'(q0.pop_front());
          exp_cnt0++;
        end else begin
          if (m1_rdata !== exp_rd || m1_err !== exp_err || m0_rdata !== 32'd0 || m0_err !== 1'b0)
            $display("FAIL %s m1_resp rdata/err got %h/%b want %h/%b", tag, m1_rdata, m1_err, exp_rd, exp_err);
          else n_pass++;
          void'(q1.pop_front());
          exp_cnt1++;
        end
        ack_m.push_back(w);
        ack_t.push_back(cyc);
      end else begin
        n_total++;
        if ({m0_rdata, m1_rdata, m0_err, m1_err} !== 66'd0)
          $display("FAIL %s idle_resp got %h %h %b %b want zeros", tag, m0_rdata, m1_rdata, m0_err, m1_err);
        else n_pass++;
      end
      drive_heads();
      if (q0.size() == 0 && q1.size() == 0 && e >= nf) break;
      if (e >= budget) begin
        n_total++;
        $display("FAIL %s timeout after %0d cycles want completion", tag, e);
        q0.delete(); q1.delete();
        drive_heads();
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({m0_ack, m1_ack, mem_re, mem_we, m0_err, m1_err} !== 6'd0 ||
        m0_rdata !== 32'd0 || m1_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
      $display("FAIL reset_outputs got ack %b%b re %b we %b addr %h want all zero", m0_ack, m1_ack, mem_re, mem_we, mem_addr);
    else n_pass++;
    n_total++;
    if ({cnt_m0, cnt_m1, cnt_conflict} !== 96'd0)
      $display("FAIL reset_counters got %0d %0d %0d want 0 0 0", cnt_m0, cnt_m1, cnt_conflict);
    else n_pass++;
  endtask

  task automatic test_write_read();
    q0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
    q0.push_back(mk(1'b0, 32'h10, 32'h0));
    run_queues("write_read", 40);
  endtask

  task automatic test_tie();
    apply_reset();
    ack_m.delete(); ack_t.delete();
    q0.push_back(mk(1'b0, 32'h20, 32'h0));
    q1.push_back(mk(1'b0, 32'h24, 32'h0));
    run_queues("tie", 40);
    n_total++;
    if (ack_m.size() != 2) $display("FAIL tie_acks got %0d want 2", ack_m.size());
    else if (ack_m[0] != 0 || ack_m[1] != 1 || ack_t[1] - ack_t[0] != 3)
      $display("FAIL tie_order got m%0d,m%0d gap %0d want m0,m1 gap 3", ack_m[0], ack_m[1], ack_t[1] - ack_t[0]);
    else n_pass++;
    n_total++;
`ifdef DMEM_ARB_STATS_EN
    if (cnt_conflict !== 32'd1) $display("FAIL tie_conflict got %0d want 1", cnt_conflict);
`else
    if (cnt_conflict !== 32'd0) $display("FAIL tie_conflict got %0d want 0", cnt_conflict);
`endif
    else n_pass++;
  endtask

  task automatic test_alternate();
    apply_reset();
    ack_m.delete(); ack_t.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_acc());
      q1.push_back(rand_acc());
    end
    run_queues("alternate", 60);
    n_total++;
    if (ack_m.size() != 6) $display("FAIL alt_count got %0d want 6", ack_m.size());
    else n_pass++;
    for (int i = 0; i < ack_m.size(); i++) begin
      n_total++;
      if (ack_m[i] != (i % 2) || (i > 0 && ack_t[i] - ack_t[i-1] != 3))
        $display("FAIL alt_order idx %0d got m%0d want m%0d", i, ack_m[i], i % 2);
      else n_pass++;
    end
  endtask

  task automatic test_range();
    q1.push_back(mk(1'b0, 32'h800, 32'h0));
    q1.push_back(mk(1'b1, 32'h7FC, 32'hA5A5_1234));
    q1.push_back(mk(1'b0, 32'h7FC, 32'h0));
    q0.push_back(mk(1'b1, 32'hFFFF_FFFC, 32'h1111_2222));
    q0.push_back(mk(1'b0, 32'h0001_0000, 32'h0));
    run_queues("range", 60);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    q0.push_back(mk(1'b1, 32'h40, 32'h0BAD_F00D));
    drive_heads();
    @(negedge clk);
    n_total++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h40)
      $display("FAIL mid_issue got we %b addr %h want 1 00000040", mem_we, mem_addr);
    else n_pass++;
    ref_mem[16] = 32'h0BAD_F00D;
    rst = 1'b1;
    q0.delete();
    drive_heads();
    @(negedge clk);
    n_total++;
    if ({m0_ack, m1_ack, mem_re, mem_we, m0_err, m1_err} !== 6'd0 || m0_rdata !== 32'd0 ||
        m1_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
      $display("FAIL mid_reset_outputs got ack %b%b re %b we %b addr %h want zeros", m0_ack, m1_ack, mem_re, mem_we, mem_addr);
    else n_pass++;
    rst = 1'b0;
    last_w = 1; exp_cnt0 = 0; exp_cnt1 = 0; exp_conf = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (m0_ack !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL mid_no_ack cycle %0d got ack %b we %b want 0 0", i, m0_ack, mem_we);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 8; round++) begin
      int n0, n1;
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      for (int i = 0; i < n0; i++) q0.push_back(rand_acc());
      for (int i = 0; i < n1; i++) q1.push_back(rand_acc());
      run_queues("random", 3 * (n0 + n1) + 10);
    end
    n_total++;
`ifdef DMEM_ARB_STATS_EN
    if (cnt_m0 !== 32'(exp_cnt0) || cnt_m1 !== 32'(exp_cnt1) || cnt_conflict !== 32'(exp_conf))
      $display("FAIL random_counters got %0d %0d %0d want %0d %0d %0d", cnt_m0, cnt_m1, cnt_conflict, exp_cnt0, exp_cnt1, exp_conf);
`else
    if ({cnt_m0, cnt_m1, cnt_conflict} !== 96'd0)
      $display("FAIL random_counters got %0d %0d %0d want 0 0 0", cnt_m0, cnt_m1, cnt_conflict);
`endif
    else n_pass++;
  endtask

  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 5; i++) q0.push_back(rand_acc());
    for (int i = 0; i < 3; i++) q1.push_back(rand_acc());
    run_queues("stats", 60);
    n_total++;
`ifdef DMEM_ARB_STATS_EN
    if (cnt_m0 !== 32'd5 || cnt_m1 !== 32'd3)
      $display("FAIL stats_counts got %0d %0d want 5 3", cnt_m0, cnt_m1);
`else
    if (cnt_m0 !== 32'd0 || cnt_m1 !== 32'd0 || cnt_conflict !== 32'd0)
      $display("FAIL stats_counts got %0d %0d %0d want 0 0 0", cnt_m0, cnt_m1, cnt_conflict);
`endif
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata = 32'd0;
    rst = 1'b1;
    q0.delete(); q1.delete();
    drive_heads();
    test_reset();
    test_write_read();
    test_tie();
    test_alternate();
    test_range();
    test_reset_mid();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
